// File: rtl/sub_pkg.sv
// sub_pkg: shared types and helpers for the digit-serial subtractor
//   state_t   : FSM state encoding (IDLE, RUN)
//   ndig      : number of digits per operand (WIDTH/DIGIT)
//   cnt_w     : digit-counter width, $clog2(NDIG+1)
//   digit_sub : reference ripple-borrow digit subtract, returns {bout, borrow_into_msb, diff}
package sub_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int MAXD = 32;
  function automatic int ndig(input int w, input int d);
    return w / d;
  endfunction
  function automatic int cnt_w(input int w, input int d);
    return $clog2(w / d + 1);
  endfunction
  // Only the low n bits of a_dig/b_dig take part; the borrow into the top used bit is reported.
  function automatic logic [MAXD+1:0] digit_sub(input logic [MAXD-1:0] a_dig, input logic [MAXD-1:0] b_dig, input logic bin, input int n);
    logic [MAXD-1:0] d;
    logic c, cm;
    d = '0;
    c = bin;
    cm = bin;
    for (int i = 0; i < MAXD; i++)
      if (i < n) begin
        cm = c;
        d[i] = a_dig[i] ^ b_dig[i] ^ c;
        c = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & c);
      end
    return {c, cm, d};
  endfunction
endpackage

// File: rtl/sub_digit.sv
// sub_digit: combinational DIGIT-bit ripple borrow chain
//   x, y : minuend / subtrahend digit
//   c    : borrow in
//   d    : difference digit
//   bo   : borrow out of the digit MSB
//   bm   : borrow into the digit MSB
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             c,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             bm
);
  logic [DIGIT:0] ch;
  assign ch[0] = c;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    assign d[i] = x[i] ^ y[i] ^ ch[i];
    assign ch[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & ch[i]);
  end
  assign bo = ch[DIGIT];
  assign bm = ch[DIGIT-1];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin, DIGIT bits per clock, start/done handshake
//   clk, rst_n (sync, active-low), start (sampled while idle), a, b, bin
//   busy (operation in progress), done (1-cycle result pulse), diff, bout, zero, ovf
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW = cnt_w(WIDTH, DIGIT);
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, acc, acc_n;
  logic [CW-1:0] cnt;
  logic brw, bo, bm, last;
  logic [DIGIT-1:0] dd;
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x (ra[DIGIT-1:0]),
    .y (rb[DIGIT-1:0]),
    .c (brw),
    .d (dd),
    .bo(bo),
    .bm(bm)
  );
  assign last = cnt == CW'(NDIG - 1);
  // New digit enters from the MSB side; after NDIG shifts the LSB digit sits at bit 0.
  assign acc_n = WIDTH'({dd, acc} >> DIGIT);
  assign busy = state == RUN;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      acc <= '0;
      brw <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        ra <= a;
        rb <= b;
        brw <= bin;
        cnt <= '0;
      end
    end else begin
      ra <= ra >> DIGIT;
      rb <= rb >> DIGIT;
      brw <= bo;
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        done <= 1'b1;
        diff <= acc_n;
        bout <= bo;
        ovf <= bm ^ bo;
        zero <= acc_n == '0;
      end
    end
endmodule
